// File: rtl/seq_detector_param_if.sv
// Serial pattern-detector port bundle: qualified bit stream, pattern load, and match outputs.
// Its N and CNT_W parameters must match those of the attached seq_detector_param.
interface seq_detector_param_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic                     in;
  logic                     in_valid;
  logic                     load;
  logic [N-1:0]             pattern_in;
  logic                     ovl;
  logic                     detected;
  logic [$clog2(N+1)-1:0]   prs_st;
  logic [CNT_W-1:0]         match_cnt;

  modport master (
    output in, in_valid, load, pattern_in, ovl,
    input  detected, prs_st, match_cnt
  );

  modport slave (
    input  in, in_valid, load, pattern_in, ovl,
    output detected, prs_st, match_cnt
  );
endinterface

// File: rtl/seq_detector_param.sv
// Mealy N-bit serial pattern detector: detected is combinational in the completing cycle; prs_st and match_cnt update one edge later.
// No backpressure (in_valid only qualifies bits). SEQ_DET_MATCH_CNT_EN builds the saturating match counter; otherwise match_cnt is tied to 0.
module seq_detector_param #(
  parameter int             N           = 4,
  parameter logic [N-1:0]   DEFAULT_PAT = N'(4'b1011),
  parameter int             CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rstn,
  seq_detector_param_if.slave sif
);

  localparam int SW = $clog2(N + 1);

  logic [N-1:0]  pat;
  logic [N-2:0]  hist;
  logic [N-2:0]  hist_nxt;
  logic [SW-1:0] fill;
  logic [SW-1:0] fill_nxt;
  logic [SW-1:0] prs_st;
  logic [SW-1:0] prs_nxt;
  logic [N-1:0]  win;
  logic          accept;
  logic          det;
  logic          hit;

  assign accept = sif.in_valid & ~sif.load;
  assign win    = {hist, sif.in};
  assign det    = accept && (fill == SW'(N - 1)) && (win == pat);

  assign sif.detected = det;
  assign sif.prs_st   = prs_st;

  // Next history/fill for an accepted bit; a non-overlapping match discards every bit it used.
  always_comb begin
    hist_nxt = win[N-2:0];
    fill_nxt = (fill == SW'(N - 1)) ? fill : fill + SW'(1);
    if (det && !sif.ovl) begin
      hist_nxt = '0;
      fill_nxt = '0;
    end
  end

  // Longest pattern prefix that matches the newest accepted bits (hist_nxt[0] is newest).
  always_comb begin
    prs_nxt = '0;
    hit     = 1'b0;
    for (int k = 1; k < N; k++) begin
      hit = (int'(fill_nxt) >= k);
      for (int i = 0; i < k; i++) begin
        if (hist_nxt[i] != pat[N-k+i]) hit = 1'b0;
      end
      if (hit) prs_nxt = SW'(k);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pat    <= DEFAULT_PAT;
      hist   <= '0;
      fill   <= '0;
      prs_st <= '0;
    end else if (sif.load) begin
      pat    <= sif.pattern_in;
      hist   <= '0;
      fill   <= '0;
      prs_st <= '0;
    end else if (sif.in_valid) begin
      hist   <= hist_nxt;
      fill   <= fill_nxt;
      prs_st <= prs_nxt;
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (sif.load) begin
      cnt <= '0;
    end else if (det && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign sif.match_cnt = cnt;
`else
  assign sif.match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param (N=4, CNT_W=2): a bit-list reference model predicts
// detected at the negedge and prs_st/match_cnt one edge later.
module tb_seq_detector_param;

  localparam int N     = 4;
  localparam int CNT_W = 2;
  localparam int SW    = $clog2(N + 1);
`ifdef SEQ_DET_MATCH_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    bit    det;
    int    prs;
    int    cnt;
    string tag;
  } exp_t;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_err;
  int   ndet;

  exp_t          sb[$];
  bit            mbits[$];
  logic [N-1:0]  mpat;
  int            mprs;
  int            mcnt;

  seq_detector_param_if #(.N(N), .CNT_W(CNT_W)) sif ();

  seq_detector_param #(
    .N           (N),
    .DEFAULT_PAT (4'b1011),
    .CNT_W       (CNT_W)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .sif  (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear(input logic [N-1:0] p);
    mbits.delete();
    mpat = p;
    mprs = 0;
    mcnt = 0;
  endtask

  // One clock of stimulus; called at posedge+1, returns at the following posedge+1.
  task automatic step(input bit v, input bit b, input bit ld, input logic [N-1:0] pin,
                      input bit o, input string tag);
    exp_t e;
    bit   det_e;
    bit   ok;
    sif.in_valid   = v;
    sif.in         = b;
    sif.load       = ld;
    sif.pattern_in = pin;
    sif.ovl        = o;

    det_e = 1'b0;
    if (v && !ld && mbits.size() == N - 1) begin
      det_e = (b == mpat[0]);
      for (int j = 0; j < N - 1; j++)
        if (mbits[j] != mpat[N-1-j]) det_e = 1'b0;
    end
    if (ld) begin
      model_clear(pin);
    end else if (v) begin
      if (det_e && !o) begin
        mbits.delete();
      end else begin
        mbits.push_back(b);
        if (mbits.size() > N - 1) void'(mbits.pop_front());
      end
      mprs = 0;
      for (int k = 1; k < N; k++) begin
        if (k <= mbits.size()) begin
          ok = 1'b1;
          for (int j = 0; j < k; j++)
            if (mbits[mbits.size()-k+j] != mpat[N-1-j]) ok = 1'b0;
          if (ok) mprs = k;
        end
      end
      if (det_e && CNT_EN != 0 && mcnt < CNT_MAX) mcnt++;
    end
    e.det = det_e;
    e.prs = mprs;
    e.cnt = mcnt;
    e.tag = tag;
    sb.push_back(e);

    @(negedge clk);
    check({tag, "_det"}, {31'd0, sif.detected}, {31'd0, sb[0].det});
    if (sif.detected) ndet++;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, "_prs"}, 32'(sif.prs_st), e.prs);
    check({e.tag, "_cnt"}, 32'(sif.match_cnt), e.cnt);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input bit o, input string tag);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, '0, o, tag);
  endtask

  // Asserted at posedge+1, held one cycle; checks the asynchronous clear before any edge.
  task automatic do_reset();
    rstn = 1'b0;
    model_clear(4'b1011);
    #1;
    check("rst_async_prs", 32'(sif.prs_st), 0);
    check("rst_async_cnt", 32'(sif.match_cnt), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    ndet = 0;
  endtask

  int prs_seq[6];

  initial begin
    n_chk = 0;
    n_err = 0;
    ndet  = 0;
    prs_seq = '{1, 2, 3, 3, 3, 3};
    model_clear(4'b1011);
    rstn           = 1'b0;
    sif.in         = 1'b1;
    sif.in_valid   = 1'b1;
    sif.load       = 1'b0;
    sif.pattern_in = '0;
    sif.ovl        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_det", {31'd0, sif.detected}, 0);
    check("reset_prs", 32'(sif.prs_st), 0);
    check("reset_cnt", 32'(sif.match_cnt), 0);
    rstn = 1'b1;

    // Default pattern, non-overlapping.
    send_bits(32'b1101_0110_1011_0101, 16, 1'b0, "nonovl");
    check("nonovl_ndet", ndet, 2);
    check("nonovl_cnt", 32'(sif.match_cnt), 2 * CNT_EN);

    // Overlap discrimination.
    do_reset();
    send_bits(32'b1011011, 7, 1'b1, "ovl1");
    check("ovl1_ndet", ndet, 2);
    check("ovl1_cnt", 32'(sif.match_cnt), 2 * CNT_EN);
    do_reset();
    send_bits(32'b1011011, 7, 1'b0, "ovl0");
    check("ovl0_ndet", ndet, 1);
    check("ovl0_cnt", 32'(sif.match_cnt), CNT_EN);

    // Runtime load with a valid bit in the load cycle.
    step(1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, "load");
    ndet = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, '0, 1'b1, "ones");
      check("ones_prs_seq", 32'(sif.prs_st), prs_seq[i]);
    end
    check("ones_ndet", ndet, 3);

    // Gaps between valid bits.
    do_reset();
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, (i != 2), 1'b0, '0, 1'b0, "gap_bit");
      if (i != 0) repeat (3) step(1'b0, 1'b1, 1'b0, '0, 1'b0, "gap_idle");
    end
    check("gap_ndet", ndet, 1);

    // Mid-sequence reset after loading a different pattern.
    step(1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, "mr_load");
    send_bits(32'b101, 3, 1'b0, "mr_pre");
    do_reset();
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, "mr_post");
    check("mr_prs", 32'(sif.prs_st), 1);
    check("mr_ndet", ndet, 0);
    send_bits(32'b011, 3, 1'b0, "mr_tail");
    check("mr_tail_ndet", ndet, 1);

    // Counter saturation: eight 1s against 1111 in overlap mode give five matches.
    step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, "sat_load");
    ndet = 0;
    send_bits(32'hFF, 8, 1'b1, "sat");
    check("sat_ndet", ndet, 5);
    check("sat_cnt", 32'(sif.match_cnt), CNT_EN * CNT_MAX);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised Mealy serial-pattern detector. It watches a 1-bit qualified input stream and flags, in the same cycle, the bit that completes an N-bit pattern. The pattern is loadable at run time, and overlapping or non-overlapping detection is selected per cycle. It is the generalised successor of the fixed 1011 Mealy detector and sits on the serial front end wherever fixed-sequence detectors were instantiated.

## Interface
- `N`, 4: pattern length in bits; legal range 2..16.
- `DEFAULT_PAT`, 4'b1011: pattern value held after reset; width N.
- `CNT_W`, 8: width of the match counter.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `in` input 1: serial data bit.
- `in_valid` input 1: `in` is consumed on this edge only when high.
- `load` input 1: capture `pattern_in` on this edge.
- `pattern_in` input N: new pattern; bit N-1 is the first bit received.
- `ovl` input 1: 1 selects overlapping detection, 0 selects non-overlapping.
- `detected` output 1: Mealy match strobe, combinational.
- `prs_st` output $clog2(N+1): registered present state, equal to the matched prefix length 0..N-1.
- `match_cnt` output CNT_W: number of matches.

## Operation
- **Registers:** `pat[N-1:0]`, `hist[N-2:0]` (last N-1 accepted bits, LSB newest), `fill` (accepted bits since clear, saturating at N-1), `prs_st`, `match_cnt`.
- **Window:** `win = {hist, in}`.
- **detected:**
  - `detected = in_valid & ~load & (fill == N-1) & (win == pat)`.
  - Purely combinational from registers and inputs; no gating by the clock.
- **Accept edge** (`in_valid=1`, `load=0`):
  - `hist` shifts left with `in` entering as the new LSB.
  - If `detected` and `ovl=0`: `fill` clears to 0 and `hist` clears to 0, so no bit of the match is reused.
  - If `detected` and `ovl=1`: `fill` stays at N-1, so the suffix can seed the next match.
  - Otherwise `fill` increments, saturating at N-1.
- **prs_st:**
  - Next value is the largest k in 0..min(fill_next, N-1) such that the newest k accepted bits equal `pat[N-1 -: k]`.
  - It is 0 after a non-overlapping match.
  - It is purely informational; `detected` does not depend on it.
- **Idle edge** (`in_valid=0`, `load=0`): all state holds.
- **Load edge:**
  - `pat` takes `pattern_in`.
  - `hist`, `fill` and `prs_st` clear to 0.
  - `match_cnt` clears to 0.
  - `in` is dropped; load wins over `in_valid`.
- **ovl** is sampled only on the edge where the match completes; changing it mid-sequence is legal.

## Timing
- **Reset values:** `pat = DEFAULT_PAT`, `hist = 0`, `fill = 0`, `prs_st = 0`, `match_cnt = 0`. Hence `detected = 0` throughout reset because `fill = 0` and N ≥ 2.
- **Reset release:** the first accepted bit is on the first rising edge with `rstn=1` and `in_valid=1`.
- **Latency:**
  - `detected` rises combinationally in the cycle the final pattern bit is presented.
  - `detected` falls after that edge unless the next bit also completes a match (overlap mode only).
  - `prs_st` and `match_cnt` update on the matching edge; latency is one cycle.
- **Reset mid-sequence:** all partial progress is discarded immediately and asynchronously.
- **Back-to-back matches:**
  - Non-overlapping: at least N accepted bits apart.
  - Overlapping: as close as the pattern's self-overlap allows, e.g. 1 bit for all-ones.

## Configuration
- **Macro:** `SEQ_DET_MATCH_CNT_EN`.
- **Defined:**
  - `match_cnt` increments on every edge where `detected=1`.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared by reset or `load`.
- **Undefined:** the counter is not built and `match_cnt` is tied to 0.

## Test plan
- **Default pattern, non-overlapping:** reset, `ovl=0`, stream 1101_0110_1011_0101 MSB first with `in_valid=1`.
  - `detected` high on bits 7 and 12 only.
  - `match_cnt=2` at the end.
- **Overlap discrimination:** stream 1011011.
  - With `ovl=1`: detects on bits 4 and 7, `match_cnt=2`.
  - With `ovl=0`: detects on bit 4 only, `match_cnt=1`.
- **Runtime load with `in_valid=1` in the load cycle:** load `pattern_in=4'b1111`, `ovl=1`, then stream six 1s.
  - The load-cycle bit is dropped.
  - Detects on bits 4, 5, 6.
  - `prs_st` sequence is 1, 2, 3, 3, 3, 3.
- **Gaps:** stream 1,0,1,1 with `in_valid` low for 3 cycles between each bit.
  - Single detect on the last valid bit.
  - `prs_st` holds during the gaps.
- **Mid-sequence reset:** after 1,0,1 assert `rstn=0` for one cycle, then send 1.
  - No detect.
  - `prs_st=1`.
  - `pat` is back to 1011 even if it was previously loaded.
- **Counter saturation:** with `CNT_W=2` and the macro defined, send 5 matches.
  - `match_cnt` sticks at 3.
  - With the macro undefined, `match_cnt` stays 0.
